// File: rtl/pid_ctrl_gen.sv
// pid_ctrl_gen: 2-stage pipelined balance PID controller with runtime gains and OFF/SOFT/RUN soft-start.
// Define PID_INT_LEAK_EN to add a (integ >>> LEAK_SHFT) leak term to the integrator update.
module pid_ctrl_gen #(
    parameter int PTCH_W    = 16,
    parameter int ERR_W     = 10,
    parameter int INT_W     = 18,
    parameter int OUT_W     = 12,
    parameter int SS_W      = 27,
    parameter int FAST_SIM  = 1,
    parameter int LEAK_SHFT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld,
    input  logic                     pwr_up,
    input  logic                     rider_off,
    input  logic signed [PTCH_W-1:0] ptch,
    input  logic signed [PTCH_W-1:0] ptch_rt,
    input  logic        [5:0]        kp,
    input  logic        [2:0]        ki_shft,
    input  logic        [3:0]        kd_shft,
    output logic signed [OUT_W-1:0]  PID_cntrl,
    output logic                     cntrl_vld,
    output logic        [7:0]        ss_tmr,
    output logic        [1:0]        state,
    output logic                     int_sat
);
    typedef enum logic [1:0] {OFF = 2'b00, SOFT = 2'b01, RUN = 2'b10} state_e;
    localparam logic [SS_W-1:0] SS_STEP = (FAST_SIM != 0) ? SS_W'(256) : SS_W'(1);

    if (LEAK_SHFT < 1 || LEAK_SHFT >= INT_W) begin : g_leak_chk
        $error("LEAK_SHFT must lie in 1..INT_W-1");
    end

    state_e                   state_q, state_d;
    logic [SS_W-1:0]          ss_q, ss_d;
    logic signed [ERR_W-1:0]  err_q, err_d, err_sat;
    logic signed [PTCH_W-1:0] rt_q, rt_d, d_sh;
    logic signed [INT_W-1:0]  integ_q, integ_d, err_ext, nxt, i_sh;
    logic signed [OUT_W-1:0]  pid_q, pid_d, pid_sat;
    logic                     v1_q, v1_d, sat_q, sat_d, cv_q, cv_d;
    logic                     ss_full, clr, ovf;
    logic signed [ERR_W+6:0]  p_term;
    logic signed [ERR_W+5:0]  i_term;
    logic signed [PTCH_W:0]   d_neg;
    logic signed [ERR_W+3:0]  d_term;
    logic signed [ERR_W+8:0]  sum;
    logic signed [ERR_W+17:0] prod, scaled;

    assign ss_tmr    = ss_q[SS_W-1 -: 8];
    assign ss_full   = ss_tmr == 8'hFF;
    assign state     = state_q;
    assign PID_cntrl = pid_q;
    assign cntrl_vld = cv_q;
    assign int_sat   = sat_q;

    always_comb begin
        state_d = state_q;
        if (!pwr_up)
            state_d = OFF;
        else if (state_q == OFF)
            state_d = SOFT;
        else if (state_q == SOFT && ss_full)
            state_d = RUN;
        ss_d = !pwr_up ? '0 : ss_full ? ss_q : ss_q + SS_STEP;
    end

    // Stage 1: saturate pitch into the error, accumulate with a sign-flip overflow guard.
    always_comb begin
        err_sat = ((&ptch[PTCH_W-1:ERR_W-1]) | ~(|ptch[PTCH_W-1:ERR_W-1])) ? ptch[ERR_W-1:0]
                : {ptch[PTCH_W-1], {(ERR_W-1){~ptch[PTCH_W-1]}}};
        err_ext = {{(INT_W-ERR_W){err_sat[ERR_W-1]}}, err_sat};
`ifdef PID_INT_LEAK_EN
        nxt = integ_q - (integ_q >>> LEAK_SHFT) + err_ext;
`else
        nxt = integ_q + err_ext;
`endif
        ovf     = (integ_q[INT_W-1] == err_sat[ERR_W-1]) && (nxt[INT_W-1] != integ_q[INT_W-1]);
        clr     = rider_off || state_q == OFF;
        integ_d = clr ? '0 : (vld && !ovf) ? nxt : integ_q;
        sat_d   = !clr && vld && ovf;
        err_d   = vld ? err_sat : err_q;
        rt_d    = vld ? ptch_rt : rt_q;
        v1_d    = vld && pwr_up;
    end

    // Stage 2: P/I/D terms, soft-start scaling, output saturation.
    always_comb begin
        p_term = (ERR_W+7)'(err_q) * (ERR_W+7)'($signed({1'b0, kp}));
        i_sh   = integ_q >>> ki_shft;
        i_term = ((&i_sh[INT_W-1:ERR_W+5]) | ~(|i_sh[INT_W-1:ERR_W+5])) ? i_sh[ERR_W+5:0]
               : {i_sh[INT_W-1], {(ERR_W+5){~i_sh[INT_W-1]}}};
        d_sh   = rt_q >>> kd_shft;
        d_neg  = -(PTCH_W+1)'(d_sh);
        d_term = ((&d_neg[PTCH_W:ERR_W+3]) | ~(|d_neg[PTCH_W:ERR_W+3])) ? d_neg[ERR_W+3:0]
               : {d_neg[PTCH_W], {(ERR_W+3){~d_neg[PTCH_W]}}};
        sum    = (ERR_W+9)'(p_term) + (ERR_W+9)'(i_term) + (ERR_W+9)'(d_term);
        prod   = (ERR_W+18)'(sum) * (ERR_W+18)'($signed({1'b0, ss_tmr}));
        scaled = '0;
        if (state_q == RUN)
            scaled = (ERR_W+18)'(sum);
        else if (state_q == SOFT)
            scaled = prod >>> 8;
        pid_sat = ((&scaled[ERR_W+17:OUT_W-1]) | ~(|scaled[ERR_W+17:OUT_W-1])) ? scaled[OUT_W-1:0]
                : {scaled[ERR_W+17], {(OUT_W-1){~scaled[ERR_W+17]}}};
        pid_d   = !pwr_up ? '0 : v1_q ? pid_sat : pid_q;
        cv_d    = pwr_up && v1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            ss_q    <= '0;
            err_q   <= '0;
            rt_q    <= '0;
            integ_q <= '0;
            v1_q    <= 1'b0;
            sat_q   <= 1'b0;
            pid_q   <= '0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ss_q    <= ss_d;
            err_q   <= err_d;
            rt_q    <= rt_d;
            integ_q <= integ_d;
            v1_q    <= v1_d;
            sat_q   <= sat_d;
            pid_q   <= pid_d;
            cv_q    <= cv_d;
        end
    end
endmodule

// File: tb/tb_pid_ctrl_gen.sv
// tb_pid_ctrl_gen: directed and randomized bench for pid_ctrl_gen against an integer reference model.
// SS_W is shortened so soft-start completes in 255 clocks.
module tb_pid_ctrl_gen;
    localparam int PTCH_W = 16, ERR_W = 10, INT_W = 18, OUT_W = 12, SS_W = 16, LEAK_SHFT = 8;
    localparam int STEP = 256;
    localparam int OFF = 0, SOFT = 1, RUN = 2;

    logic clk = 0, rst_n = 1, vld = 0, pwr_up = 0, rider_off = 0;
    logic signed [PTCH_W-1:0] ptch = '0, ptch_rt = '0;
    logic [5:0] kp = '0;
    logic [2:0] ki_shft = '0;
    logic [3:0] kd_shft = '0;
    logic signed [OUT_W-1:0] PID_cntrl;
    logic cntrl_vld, int_sat;
    logic [7:0] ss_tmr;
    logic [1:0] state;

    int tests = 0, fails = 0;
    int m_pid, m_cnt, m_state, m_integ, m_err, m_rt;
    bit m_cv, m_v1, m_sat;
    bit chk_en = 0, lit_en = 0;
    logic [23:0] lit_vec, dut_vec, mdl_vec;
    string lit_name;

    always #5 clk = ~clk;

    pid_ctrl_gen #(.PTCH_W(PTCH_W), .ERR_W(ERR_W), .INT_W(INT_W), .OUT_W(OUT_W), .SS_W(SS_W),
                   .FAST_SIM(1), .LEAK_SHFT(LEAK_SHFT)) dut (
        .clk(clk), .rst_n(rst_n), .vld(vld), .pwr_up(pwr_up), .rider_off(rider_off),
        .ptch(ptch), .ptch_rt(ptch_rt), .kp(kp), .ki_shft(ki_shft), .kd_shft(kd_shft),
        .PID_cntrl(PID_cntrl), .cntrl_vld(cntrl_vld), .ss_tmr(ss_tmr), .state(state), .int_sat(int_sat)
    );

    function automatic int sat(int x, int w);
        int mx, mn;
        mx = (1 << (w - 1)) - 1;
        mn = -(1 << (w - 1));
        return x > mx ? mx : x < mn ? mn : x;
    endfunction

    function automatic int pid_calc(int e, int ig, int rt, int k_p, int k_i, int k_d, int st, int tm);
        int s;
        s = e * k_p + sat(ig >>> k_i, ERR_W + 6) + sat(-(rt >>> k_d), ERR_W + 4);
        if (st == SOFT) s = (s * tm) >>> 8;
        else if (st == OFF) s = 0;
        return sat(s, OUT_W);
    endfunction

    function automatic logic [23:0] pack(int pid, int cv, int tm, int st, int s);
        return {pid[OUT_W-1:0], cv[0], tm[7:0], st[1:0], s[0]};
    endfunction

    assign dut_vec = {PID_cntrl, cntrl_vld, ss_tmr, state, int_sat};
    assign mdl_vec = pack(m_pid, m_cv, m_cnt >> (SS_W - 8), m_state, m_sat);

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (dut_vec !== mdl_vec) begin
                fails++;
                $display("FAIL model t=%0t {pid,vld,tmr,state,sat} dut=%h expected=%h", $time, dut_vec, mdl_vec);
            end
        end
        if (lit_en) begin
            tests++;
            if (dut_vec !== lit_vec || mdl_vec !== lit_vec) begin
                fails++;
                $display("FAIL %s dut=%h model=%h expected=%h", lit_name, dut_vec, mdl_vec, lit_vec);
            end
        end
    end

    task automatic model_reset();
        m_pid = 0; m_cnt = 0; m_state = OFF; m_integ = 0; m_err = 0; m_rt = 0;
        m_cv = 0; m_v1 = 0; m_sat = 0;
    endtask

    task automatic model_step();
        int tm, e, nxt, n_pid, n_integ, n_state;
        bit n_cv, n_sat;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tm = m_cnt >> (SS_W - 8);
        n_cv = 0;
        n_pid = m_pid;
        if (!pwr_up) n_pid = 0;
        else if (m_v1) begin
            n_pid = pid_calc(m_err, m_integ, m_rt, kp, ki_shft, kd_shft, m_state, tm);
            n_cv = 1;
        end
        e = sat(ptch, ERR_W);
        n_sat = 0;
        n_integ = m_integ;
        if (rider_off || m_state == OFF) n_integ = 0;
        else if (vld) begin
`ifdef PID_INT_LEAK_EN
            nxt = m_integ - (m_integ >>> LEAK_SHFT) + e;
`else
            nxt = m_integ + e;
`endif
            if (nxt > (1 << (INT_W - 1)) - 1 || nxt < -(1 << (INT_W - 1))) n_sat = 1;
            else n_integ = nxt;
        end
        if (vld) begin
            m_err = e;
            m_rt = ptch_rt;
        end
        m_v1 = vld && pwr_up;
        n_state = !pwr_up ? OFF : m_state == OFF ? SOFT : (m_state == SOFT && tm == 255) ? RUN : m_state;
        m_cnt = !pwr_up ? 0 : tm == 255 ? m_cnt : m_cnt + STEP;
        m_state = n_state; m_integ = n_integ; m_pid = n_pid; m_cv = n_cv; m_sat = n_sat;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
        lit_en = 0;
    endtask

    task automatic expect_lit(string n, logic [23:0] v);
        lit_name = n;
        lit_vec = v;
        lit_en = 1;
    endtask

    task automatic send(int p, int r, int k_p, int k_i, int k_d, bit ro);
        ptch = PTCH_W'(p); ptch_rt = PTCH_W'(r);
        kp = 6'(k_p); ki_shft = 3'(k_i); kd_shft = 4'(k_d);
        rider_off = ro; vld = 1;
        tick();
        vld = 0; rider_off = 0;
    endtask

    initial begin
        int r;
        #1 rst_n = 0;
        model_reset();
        chk_en = 1;
        repeat (3) tick();
        expect_lit("reset", '0);
        tick();
        pwr_up = 1; rst_n = 1;
        while ((m_cnt >> (SS_W - 8)) != 127) tick();
        send(40, 0, 10, 7, 0, 1);
        tick();
        expect_lit("soft_scale", pack(200, 1, 129, SOFT, 0));
        while (m_state != RUN) tick();
        rider_off = 1; tick(); rider_off = 0;
        send(16, 0, 9, 1, 6, 0);
        tick();
        expect_lit("run_152", pack(152, 1, 255, RUN, 0));
        send(28672, -32768, 63, 1, 6, 0);
        tick();
        expect_lit("sat_pos", pack(2047, 1, 255, RUN, 0));
        send(-28672, 32767, 63, 1, 6, 0);
        tick();
        expect_lit("sat_neg", pack(-2048, 1, 255, RUN, 0));
        rider_off = 1; tick(); rider_off = 0;
        send(97, 0, 3, 7, 0, 0);
        tick();
        expect_lit("pid_0x123", pack(291, 1, 255, RUN, 0));
        tick();
        rst_n = 0;
        model_reset();
        expect_lit("reset_midrun", '0);
        repeat (2) tick();
        rst_n = 1;
        while (m_state != RUN) tick();
        rider_off = 1; tick(); rider_off = 0;
        ptch = 511; ptch_rt = 0; kp = 1; ki_shft = 7; kd_shft = 0; vld = 1;
        repeat (257) tick();
        expect_lit("int_guard", pack(1533, 1, 255, RUN, 1));
        repeat (40) tick();
        rider_off = 1;
        tick();
        rider_off = 0; vld = 0;
        tick();
        expect_lit("rider_clear", pack(511, 1, 255, RUN, 0));
        send(5, 0, 1, 0, 0, 0);
        pwr_up = 0; vld = 1; ptch = 5;
        tick();
        vld = 0;
        expect_lit("pwr_drop", '0);
        tick();
        pwr_up = 1;
        for (int i = 0; i < 3000; i++) begin
            vld = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 1200);
            ptch = ($urandom_range(0, 3) == 0) ? PTCH_W'($urandom) : PTCH_W'(r - 600);
            ptch_rt = ($urandom_range(0, 1) == 0) ? PTCH_W'($urandom) : PTCH_W'(r - 600);
            kp = 6'($urandom); ki_shft = 3'($urandom); kd_shft = 4'($urandom);
            rider_off = $urandom_range(0, 31) == 0;
            if (pwr_up) pwr_up = $urandom_range(0, 299) != 0;
            else pwr_up = $urandom_range(0, 3) == 0;
            tick();
        end
        vld = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
